// File: rtl/display_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_sync_ctrl
//  Description : Frame-synchronous snapshot handshake between the game FSM
//                and the display path, plus paced community-card reveal.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_sync_ctrl #(
    parameter int W             = 64,
    parameter int REVEAL_FRAMES = 30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         vs,
    input  logic         upd_req,
    input  logic [W-1:0] game_bus,
    input  logic [2:0]   board_target,
    output logic         upd_ack,
    output logic [W-1:0] disp_bus,
    output logic [2:0]   shown_cnt,
    output logic         reveal_busy,
    output logic [15:0]  frame_cnt
);

    localparam logic [7:0] TMR_LAST  = 8'(REVEAL_FRAMES - 1);
    localparam logic [2:0] MAX_SHOWN = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
    logic           live_q, live_d;
    logic           armed_q, armed_d;
    logic [W-1:0]   disp_bus_q, disp_bus_d;
    logic           upd_ack_q, upd_ack_d;
    logic [2:0]     shown_q, shown_d;
    logic [2:0]     target_q, target_d;
    logic [7:0]     tmr_q, tmr_d;
    logic [15:0]    frame_q, frame_d;

    logic           vs_fall;
    logic           commit;
    logic [2:0]     bt_clamp;

    // Next-state logic: sync chain, handshake FSM, snapshot, reveal pacing.
    always_comb begin
        s1_d       = vs;
        s2_d       = s1_q;
        s3_d       = s2_q;
        // s1 only reflects the real vs one edge after reset; the detector is
        // armed once a genuine high level has been seen so that a vs already
        // low at reset release cannot produce a phantom frame start.
        live_d     = 1'b1;
        armed_d    = armed_q | (live_q & s1_q);
        vs_fall    = s3_q & ~s2_q & armed_q;

        state_d    = state_q;
        commit     = 1'b0;
        disp_bus_d = disp_bus_q;
        shown_d    = shown_q;
        target_d   = target_q;
        tmr_d      = tmr_q;
        frame_d    = frame_q;
        bt_clamp   = (board_target > MAX_SHOWN) ? MAX_SHOWN : board_target;

        case (state_q)
            IDLE: begin
                if (upd_req) state_d = PEND;
            end
            PEND: begin
                if (!upd_req) begin
                    state_d = IDLE;
                end else if (vs_fall) begin
                    commit  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        upd_ack_d = (state_d == ACK);

        if (vs_fall) frame_d = frame_q + 16'd1;

        // A commit restarts pacing and wins over a reveal step on the same edge.
        if (commit) begin
            disp_bus_d = game_bus;
            target_d   = bt_clamp;
            tmr_d      = 8'd0;
            if (bt_clamp < shown_q) shown_d = bt_clamp;
        end else if (vs_fall && (shown_q < target_q)) begin
            if (tmr_q == TMR_LAST) begin
                shown_d = shown_q + 3'd1;
                tmr_d   = 8'd0;
            end else begin
                tmr_d   = tmr_q + 8'd1;
            end
        end
    end

    // State register with synchronous reset; sync chain idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            live_q     <= 1'b0;
            armed_q    <= 1'b0;
            disp_bus_q <= '0;
            upd_ack_q  <= 1'b0;
            shown_q    <= 3'd0;
            target_q   <= 3'd0;
            tmr_q      <= 8'd0;
            frame_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            live_q     <= live_d;
            armed_q    <= armed_d;
            disp_bus_q <= disp_bus_d;
            upd_ack_q  <= upd_ack_d;
            shown_q    <= shown_d;
            target_q   <= target_d;
            tmr_q      <= tmr_d;
            frame_q    <= frame_d;
        end
    end

    assign upd_ack     = upd_ack_q;
    assign disp_bus    = disp_bus_q;
    assign shown_cnt   = shown_q;
    assign reveal_busy = (shown_q != target_q);
    assign frame_cnt   = frame_q;

endmodule
`default_nettype wire
